// File: rtl/active_hwt_seq.sv
// -----------------------------------------------------------------------------
// active_hwt_seq
// Registered bitwise datapath Y = D & ((A & B) | C) with a trigger sequencer
// watching A. TRIG_COUNT consecutive enabled cycles with A == TRIG_PATTERN move
// the sequencer through IDLE -> ARM -> FIRE. While in FIRE, every registered Y
// is XORed with PAYLOAD_MASK for PAYLOAD_CYCLES enabled cycles, or forever when
// STICKY is set.
//
// Ports
//   clk     in   1      rising-edge clock
//   rst_n   in   1      asynchronous active-low reset
//   en      in   1      cycle enable; when low, Y and all sequencer state hold
//   A..D    in   WIDTH  data operands (A also feeds the trigger compare)
//   Y       out  WIDTH  registered result, one cycle latency
//   trig    out  1      state is FIRE
//   armed   out  1      state is ARM
// -----------------------------------------------------------------------------
module active_hwt_seq #(
   parameter int               WIDTH          = 4,
   parameter logic [WIDTH-1:0] TRIG_PATTERN   = WIDTH'(4'hA),
   parameter int               TRIG_COUNT     = 3,
   parameter int               PAYLOAD_CYCLES = 8,
   parameter logic [WIDTH-1:0] PAYLOAD_MASK   = '1,
   parameter bit               STICKY         = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [WIDTH-1:0] C,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Y,
   output logic             trig,
   output logic             armed
);

   localparam int CNT_W = $clog2(TRIG_COUNT + 1);
   localparam int PAY_W = $clog2(PAYLOAD_CYCLES + 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_ARM  = 2'd1;
   localparam logic [1:0] S_FIRE = 2'd2;

   localparam logic [CNT_W-1:0] TRIG_CNT_V = CNT_W'(TRIG_COUNT);
   localparam logic [PAY_W-1:0] PAY_LOAD_V = PAY_W'(PAYLOAD_CYCLES);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_match_cnt;
   logic [PAY_W-1:0] r_pay_cnt;
   logic [WIDTH-1:0] r_y_p1;

   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] w_cnt_inc;
   logic [PAY_W-1:0] w_pay_nxt;
   logic             w_match;
   logic             w_fire;
   logic [WIDTH-1:0] w_y_nom;
   logic [WIDTH-1:0] w_y_p0;

   // ---- stage p0: combinational datapath and sequencer next-state ----
   assign w_match   = (A == TRIG_PATTERN);
   assign w_fire    = (r_state == S_FIRE);
   assign w_cnt_inc = r_match_cnt + CNT_W'(1);
   assign w_y_nom   = D & ((A & B) | C);
   // Corruption follows the state held during this cycle, not the next one.
   assign w_y_p0    = w_y_nom ^ (w_fire ? PAYLOAD_MASK : '0);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_match_cnt;
      w_pay_nxt   = r_pay_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_match) begin
               if (TRIG_COUNT == 1) begin
                  w_state_nxt = S_FIRE;
                  w_cnt_nxt   = '0;
                  w_pay_nxt   = PAY_LOAD_V;
               end else begin
                  w_state_nxt = S_ARM;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end else begin
               w_cnt_nxt = '0;
            end
         end
         S_ARM: begin
            if (w_match) begin
               if (w_cnt_inc == TRIG_CNT_V) begin
                  w_state_nxt = S_FIRE;
                  w_cnt_nxt   = '0;
                  w_pay_nxt   = PAY_LOAD_V;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end else begin
               // A broken run forfeits all accumulated matches.
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         S_FIRE: begin
            // A is ignored here, so a match on the exit edge earns no credit.
            if (!STICKY) begin
               if (r_pay_cnt <= PAY_W'(1)) begin
                  w_state_nxt = S_IDLE;
                  w_pay_nxt   = '0;
               end else begin
                  w_pay_nxt = r_pay_cnt - PAY_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_pay_nxt   = '0;
         end
      endcase
   end

   // ---- stage p1: registered result and sequencer state ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_match_cnt <= '0;
         r_pay_cnt   <= '0;
         r_y_p1      <= '0;
      end else if (en) begin
         r_state     <= w_state_nxt;
         r_match_cnt <= w_cnt_nxt;
         r_pay_cnt   <= w_pay_nxt;
         r_y_p1      <= w_y_p0;
      end
   end

   assign Y     = r_y_p1;
   assign trig  = (r_state == S_FIRE);
   assign armed = (r_state == S_ARM);

endmodule

// File: tb/tb_active_hwt_seq.sv
module tb_active_hwt_seq;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       rst_n_s;
   logic       en;
   logic [3:0] A, B, C, D;
   logic [3:0] Y, Ys;
   logic       trig, armed, trig_s, armed_s;

   always #5 clk = ~clk;

   active_hwt_seq u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .Y     (Y),
      .trig  (trig),
      .armed (armed)
   );

   active_hwt_seq #(.STICKY(1'b1)) u_sticky (
      .clk   (clk),
      .rst_n (rst_n_s),
      .en    (en),
      .A     (A),
      .B     (B),
      .C     (C),
      .D     (D),
      .Y     (Ys),
      .trig  (trig_s),
      .armed (armed_s)
   );

   typedef struct {
      logic [3:0] y;
      logic       t;
      logic       a;
      logic [3:0] sy;
      logic       st;
      string      nm;
   } exp_t;

   exp_t q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   // Expectations for the sticky instance, set by the driver per phase.
   logic       rs_g = 1'b0;
   logic [3:0] sy_g = 4'h0;
   logic       st_g = 1'b0;

   task automatic check(input exp_t e);
      n_vec++;
      if ({Y, trig, armed, Ys, trig_s} !== {e.y, e.t, e.a, e.sy, e.st}) begin
         n_bad++;
         $display("FAIL %s: got Y=%h trig=%b armed=%b Ys=%h trig_s=%b, required Y=%h trig=%b armed=%b Ys=%h trig_s=%b",
                  e.nm, Y, trig, armed, Ys, trig_s, e.y, e.t, e.a, e.sy, e.st);
      end
   endtask

   // Monitor: one output beat per clock, compared just after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check(e);
         end
      end
   end

   task automatic step(input logic r, input logic e,
                       input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c, input logic [3:0] d,
                       input logic [3:0] ey, input logic et, input logic ea,
                       input string nm);
      exp_t x;
      @(negedge clk);
      rst_n   = r;
      rst_n_s = rs_g;
      en      = e;
      A = a; B = b; C = c; D = d;
      x.y = ey; x.t = et; x.a = ea; x.sy = sy_g; x.st = st_g; x.nm = nm;
      q.push_back(x);
   endtask

   // Trigger-oriented vector: B=F, C=0, D=F so the nominal result equals A.
   task automatic mt(input logic [3:0] a, input logic [3:0] ey,
                     input logic et, input logic ea, input string nm);
      step(1'b1, 1'b1, a, 4'hF, 4'h0, 4'hF, ey, et, ea, nm);
   endtask

   initial begin
      exp_t x;
      rst_n = 1'b0; rst_n_s = 1'b0; en = 1'b0;
      A = 4'h0; B = 4'h0; C = 4'h0; D = 4'h0;

      // Reset held with a matching A on the bus.
      repeat (5) step(1'b0, 1'b1, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "reset_hold");

      // Nominal datapath.
      step(1'b1, 1'b1, 4'hF, 4'h3, 4'h4, 4'hE, 4'h6, 1'b0, 1'b0, "nom_F34E");
      step(1'b1, 1'b1, 4'h5, 4'hC, 4'h1, 4'h7, 4'h5, 1'b0, 1'b0, "nom_5C17");
      step(1'b1, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "nom_0F0F");

      // Near miss: run broken after two matches, restarts at one.
      mt(4'hA, 4'hA, 1'b0, 1'b1, "near_m1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "near_m2");
      mt(4'h2, 4'h2, 1'b0, 1'b0, "near_break");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "near_restart1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "near_restart2");
      mt(4'h0, 4'h0, 1'b0, 1'b0, "near_drop");

      // Full fire with A held at the pattern.
      mt(4'hA, 4'hA, 1'b0, 1'b1, "fire_e1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "fire_e2");
      mt(4'hA, 4'hA, 1'b1, 1'b0, "fire_e3");
      repeat (7) mt(4'hA, 4'h5, 1'b1, 1'b0, "fire_payload");
      mt(4'hA, 4'h5, 1'b0, 1'b0, "fire_e11_exit");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "fire_e12_rearm");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "fire_e13");
      mt(4'h0, 4'h0, 1'b0, 1'b0, "fire_e14_drop");

      // Enable gating in ARM and in FIRE.
      mt(4'hA, 4'hA, 1'b0, 1'b1, "gate_m1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "gate_m2");
      repeat (4) step(1'b1, 1'b0, 4'h2, 4'h0, 4'hF, 4'h0, 4'hA, 1'b0, 1'b1, "gate_arm_hold");
      mt(4'hA, 4'hA, 1'b1, 1'b0, "gate_m3");
      repeat (3) mt(4'hA, 4'h5, 1'b1, 1'b0, "gate_pay_a");
      repeat (4) step(1'b1, 1'b0, 4'h0, 4'hF, 4'hF, 4'hF, 4'h5, 1'b1, 1'b0, "gate_fire_hold");
      repeat (4) mt(4'hA, 4'h5, 1'b1, 1'b0, "gate_pay_b");
      mt(4'hA, 4'h5, 1'b0, 1'b0, "gate_exit");
      // The exit-edge match must not count: three more are needed to fire.
      mt(4'hA, 4'hA, 1'b0, 1'b1, "post_exit_m1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "post_exit_m2");
      mt(4'hA, 4'hA, 1'b1, 1'b0, "post_exit_m3");

      // Reset in the middle of FIRE.
      mt(4'hA, 4'h5, 1'b1, 1'b0, "rf_e4");
      mt(4'hA, 4'h5, 1'b1, 1'b0, "rf_e5");
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      x.y = 4'h0; x.t = 1'b0; x.a = 1'b0; x.sy = 4'h0; x.st = 1'b0; x.nm = "rf_async";
      check(x);
      repeat (2) step(1'b0, 1'b1, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "rf_hold");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "rf_m1");
      mt(4'hA, 4'hA, 1'b0, 1'b1, "rf_m2");
      mt(4'hA, 4'hA, 1'b1, 1'b0, "rf_m3");
      mt(4'hA, 4'h5, 1'b1, 1'b0, "rf_pay");

      // Sticky instance; main instance held in reset.
      rs_g = 1'b1;
      sy_g = 4'hA; st_g = 1'b0;
      repeat (2) step(1'b0, 1'b1, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "sticky_arm");
      st_g = 1'b1;
      step(1'b0, 1'b1, 4'hA, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "sticky_fire");
      sy_g = 4'hF;
      repeat (110) step(1'b0, 1'b1, 4'h0, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0, "sticky_hold");

      @(posedge clk);
      #2;
      n_vec++;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, required bench completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/active_hwt_seq.md
ACTIVE_HWT_SEQ -- requirements
Module: active_hwt_seq

Interface
REQ-001 Parameter WIDTH, default 4: bit width of data channels A, B, C, D, Y (>=1).
REQ-002 Parameter TRIG_PATTERN, default 4'hA (WIDTH bits): value of A that counts as a trigger match.
REQ-003 Parameter TRIG_COUNT, default 3: consecutive enabled matches required to fire (>=1).
REQ-004 Parameter PAYLOAD_CYCLES, default 8: enabled cycles spent in FIRE (>=1).
REQ-005 Parameter PAYLOAD_MASK, default all ones (WIDTH bits): XOR mask applied to Y while firing.
REQ-006 Parameter STICKY, default 0: 1 = FIRE never exits except by reset.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 en  input  1  cycle enable for datapath and trigger logic.
REQ-010 A, B, C, D  input  WIDTH each  data operands; A also observed by the trigger.
REQ-011 Y  output  WIDTH  registered data result.
REQ-012 trig  output  1  high while state is FIRE (decode of state register).
REQ-013 armed  output  1  high while state is ARM.

Function
REQ-014 Nominal function per bit i: y_nom[i] = D[i] & ((A[i] & B[i]) | C[i]).
REQ-015 On an edge with en=1: Y <= y_nom ^ (current state==FIRE ? PAYLOAD_MASK : 0); latency exactly 1 cycle.
REQ-016 On an edge with en=0: Y, state, match counter and payload counter all hold.
REQ-017 States: IDLE, ARM, FIRE; state register updates on the same edge as Y, using current-cycle inputs.
REQ-018 match = (A == TRIG_PATTERN), full-width compare; B, C, D do not affect the trigger.
REQ-019 IDLE: match -> ARM with count=1, or -> FIRE directly if TRIG_COUNT==1; no match -> stay, count=0.
REQ-020 ARM: match -> count+1; when count+1 == TRIG_COUNT -> FIRE, count=0, payload counter loaded with PAYLOAD_CYCLES.
REQ-021 ARM: no match -> IDLE, count=0 (no partial credit retained).
REQ-022 FIRE: A ignored; payload counter decrements per enabled edge; at the edge where it reaches 0 -> IDLE (STICKY=0).
REQ-023 FIRE exit edge: a match on that edge is not counted; re-arming starts on the following enabled edge.
REQ-024 STICKY=1: FIRE holds indefinitely; payload counter is irrelevant and frozen.
REQ-025 Counter widths: match counter $clog2(TRIG_COUNT+1), payload counter $clog2(PAYLOAD_CYCLES+1); neither wraps.
REQ-026 Timeline (defaults): matches at edges 1,2,3 -> trig high after edge 3; corrupted Y at edges 4..11; trig low after edge 11.

Reset
REQ-027 rst_n low asynchronously forces Y=0, state=IDLE, both counters 0, trig=0, armed=0, regardless of clk or en.
REQ-028 Reset asserted mid-ARM or mid-FIRE discards all progress; first enabled edge after release behaves as from IDLE.
REQ-029 No output takes X after reset; reset release is synchronised externally.

Verification
REQ-030 Reset: rst_n=0 with A=4'hA for 5 clocks -> Y=0, trig=0, armed=0 throughout.
REQ-031 Nominal: A=4'hF, B=4'h3, C=4'h4, D=4'hE, en=1 -> Y=4'h6 one edge later, trig=0.
REQ-032 Near-miss: A=4'hA, 4'hA, 4'h2, 4'hA -> armed 1,1,0,1; trig never high; count restarts at 1.
REQ-033 Fire: A=4'hA, B=4'hF, C=0, D=4'hF for 3 edges then hold -> Y=4'hA until edge 3, Y=4'h5 at edges 4..11, Y=4'hA from edge 12; trig high exactly 8 cycles.
REQ-034 Enable gating: en=0 for 4 cycles between 2nd and 3rd match, and again mid-FIRE -> count, payload counter, Y held; fire and payload lengths unchanged in enabled cycles.
REQ-035 Reset mid-FIRE (edge 6) -> Y=0, trig=0 immediately; next 3 matches fire again; STICKY=1 build: trig remains high 100+ cycles after firing.
